payload_mismatch_monitor: RTL and testbench

- Runtime detector placed directly downstream of the payload stage of the victim logic.
- Each valid cycle it compares the tapped functional output against the golden-model output of the same cycle.
- It counts mismatches in tumbling windows and raises a sticky alarm when a window reaches a threshold.
- It captures the timestamp and difference pattern of the first mismatch, for correlation with parasitic-extraction and ML feature logs.

---
 rtl/payload_mismatch_monitor.sv | 143 ++++++++++++++
 tb/tb_payload_mismatch_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/payload_mismatch_monitor.sv
// Runtime payload mismatch monitor.
// Compares a tapped functional output against the golden-model output on each
// valid monitoring cycle. Mismatches are counted in tumbling windows, and a
// sticky alarm is raised when one window reaches THRESH mismatches. The
// timestamp and difference pattern of the first mismatch are captured so they
// can be correlated with external logs.
module payload_mismatch_monitor #(
  parameter int WIDTH   = 1,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3,
  parameter int CNT_W   = 8,
  parameter int TS_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid,
  input  logic [WIDTH-1:0] dut_out,
  input  logic [WIDTH-1:0] golden_out,
  input  logic             clear,
  output logic             alarm,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [TS_W-1:0]  first_ts,
  output logic [WIDTH-1:0] first_diff,
  output logic             ts_valid,
  output logic [1:0]       state
);

  localparam int IDX_W = $clog2(WIN_LEN);
  localparam int WC_W  = $clog2(WIN_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_MONITOR = 2'b01,
    S_ALARM   = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [TS_W-1:0]  timestamp;
  logic [IDX_W-1:0] win_idx;
  logic [WC_W-1:0]  win_cnt;

  logic [WIDTH-1:0] diff;
  logic             mis;
  logic             sample;
  logic             last_in_win;
  logic             trigger;
  logic [WC_W-1:0]  win_cnt_inc;

  // A sample is a valid cycle in MONITOR; clear in the same cycle drops it.
  assign diff        = dut_out ^ golden_out;
  assign mis         = |diff;
  assign sample      = (state_q == S_MONITOR) && valid && !clear;
  assign win_cnt_inc = win_cnt + WC_W'(mis);
  assign last_in_win = (win_idx == IDX_W'(WIN_LEN - 1));
  // The threshold check uses the count including this sample, even on the
  // last sample of a window, before the window counters roll over.
  assign trigger     = sample && mis && (win_cnt_inc >= WC_W'(THRESH));

  assign state = state_q;
  assign alarm = (state_q == S_ALARM);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: clear overrides everything, ALARM is otherwise sticky.
  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = en ? S_MONITOR : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (en) state_d = S_MONITOR;
        S_MONITOR: begin
          if (trigger)  state_d = S_ALARM;
          else if (!en) state_d = S_IDLE;
        end
        S_ALARM:   state_d = S_ALARM;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Free-running saturating timestamp, advancing only while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             timestamp <= '0;
    else if (en && (timestamp != '1))    timestamp <= timestamp + TS_W'(1);
  end

  // Tumbling window position and per-window mismatch count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_idx <= '0;
      win_cnt <= '0;
    end else if (clear) begin
      win_idx <= '0;
      win_cnt <= '0;
    end else if (state_q == S_MONITOR) begin
      if (!en && !trigger) begin
        win_idx <= '0;
        win_cnt <= '0;
      end else if (sample) begin
        if (last_in_win) begin
          win_idx <= '0;
          win_cnt <= '0;
        end else begin
          win_idx <= win_idx + IDX_W'(1);
          win_cnt <= win_cnt_inc;
        end
      end
    end
  end

  // Total mismatch counter and first-mismatch capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_cnt <= '0;
      first_ts     <= '0;
      first_diff   <= '0;
      ts_valid     <= 1'b0;
    end else if (clear) begin
      mismatch_cnt <= '0;
      first_ts     <= '0;
      first_diff   <= '0;
      ts_valid     <= 1'b0;
    end else if (sample && mis) begin
      if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
      if (!ts_valid) begin
        first_ts   <= timestamp;
        first_diff <= diff;
        ts_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_payload_mismatch_monitor.sv
// Self-checking bench for payload_mismatch_monitor. Two instances share the
// stimulus: one with default parameters, one with a 2-bit mismatch counter so
// saturation is reachable. A behavioural model tracks the expected outputs.
module tb_payload_mismatch_monitor;

  localparam int WIN_LEN = 16;
  localparam int THRESH  = 3;
  localparam int TS_MAX  = 65535;

  logic clk = 1'b0;
  logic rst, en, valid, clear;
  logic [0:0] dut_out, golden_out;

  logic        alarm_a, ts_valid_a;
  logic [7:0]  cnt_a;
  logic [15:0] first_ts_a;
  logic [0:0]  first_diff_a;
  logic [1:0]  state_a;

  logic        alarm_s, ts_valid_s;
  logic [1:0]  cnt_s;
  logic [15:0] first_ts_s;
  logic [0:0]  first_diff_s;
  logic [1:0]  state_s;

  payload_mismatch_monitor u_dut_a (
    .clk(clk), .rst(rst), .en(en), .valid(valid), .dut_out(dut_out),
    .golden_out(golden_out), .clear(clear), .alarm(alarm_a),
    .mismatch_cnt(cnt_a), .first_ts(first_ts_a), .first_diff(first_diff_a),
    .ts_valid(ts_valid_a), .state(state_a)
  );

  payload_mismatch_monitor #(.CNT_W(2)) u_dut_s (
    .clk(clk), .rst(rst), .en(en), .valid(valid), .dut_out(dut_out),
    .golden_out(golden_out), .clear(clear), .alarm(alarm_s),
    .mismatch_cnt(cnt_s), .first_ts(first_ts_s), .first_diff(first_diff_s),
    .ts_valid(ts_valid_s), .state(state_s)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: mode 0 idle, 1 monitoring, 2 alarmed.
  int m_mode, m_tot, m_ts, m_fts, m_fdiff;
  bit m_tsv;
  bit win_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_tot = 0; m_ts = 0; m_fts = 0; m_fdiff = 0; m_tsv = 0;
    win_q.delete();
  endtask

  // One clock edge of the reference behaviour, using the current inputs.
  task automatic model_step();
    int diffv, hits;
    bit mis;
    diffv = int'(dut_out ^ golden_out);
    mis   = (diffv != 0);
    if (clear) begin
      m_tot = 0; m_tsv = 0; m_fts = 0; m_fdiff = 0;
      win_q.delete();
      m_mode = en ? 1 : 0;
    end else if (m_mode == 1 && valid) begin
      if (mis) begin
        m_tot++;
        if (!m_tsv) begin
          m_tsv = 1; m_fts = m_ts; m_fdiff = diffv;
        end
      end
      win_q.push_back(mis);
      hits = 0;
      foreach (win_q[i]) hits += int'(win_q[i]);
      if (win_q.size() == WIN_LEN) win_q.delete();
      if (mis && hits >= THRESH) m_mode = 2;
      else if (!en) begin
        m_mode = 0; win_q.delete();
      end
    end else if (m_mode == 1 && !en) begin
      m_mode = 0; win_q.delete();
    end else if (m_mode == 0 && en) begin
      m_mode = 1;
    end
    if (en && m_ts < TS_MAX) m_ts++;
  endtask

  task automatic check_all();
    check("state", state_a, m_mode);
    check("alarm", alarm_a, (m_mode == 2) ? 1 : 0);
    check("cnt", cnt_a, (m_tot > 255) ? 255 : m_tot);
    check("cnt_sat", cnt_s, (m_tot > 3) ? 3 : m_tot);
    check("first_ts", first_ts_a, m_fts);
    check("first_diff", first_diff_a, m_fdiff);
    check("ts_valid", ts_valid_a, m_tsv);
    check("state_sat", state_s, m_mode);
  endtask

  // Apply current inputs for one edge, then compare at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic sample_cycle(input bit mism);
    valid      = 1'b1;
    golden_out = 1'($urandom_range(1));
    dut_out    = golden_out ^ mism;
    cycle();
  endtask

  // Asynchronous reset mid-cycle: outputs must drop before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_state", state_a, 0);
    check("rst_alarm", alarm_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_cnt_sat", cnt_s, 0);
    check("rst_first_ts", first_ts_a, 0);
    check("rst_first_diff", first_diff_a, 0);
    check("rst_ts_valid", ts_valid_a, 0);
    en = 1'b0; valid = 1'b0; clear = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int t0;
    rst = 1'b1; en = 1'b0; valid = 1'b0; clear = 1'b0;
    dut_out = 1'b0; golden_out = 1'b0;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Matching data only: never an alarm, count or capture.
    en = 1'b1; valid = 1'b0;
    cycle();
    for (int i = 0; i < 40; i++) sample_cycle(1'b0);
    check("t1_alarm", alarm_a, 0);
    check("t1_cnt", cnt_a, 0);
    check("t1_tsv", ts_valid_a, 0);
    check("t1_state", state_a, 1);

    // Single mismatch when the timestamp reads 5.
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (m_ts == 0) begin
        valid = 1'b0;
        cycle();
      end else begin
        sample_cycle(m_ts == 5);
      end
    end
    check("t2_first_ts", first_ts_a, 5);
    check("t2_first_diff", first_diff_a, 1);
    check("t2_tsv", ts_valid_a, 1);
    check("t2_cnt", cnt_a, 1);
    check("t2_alarm", alarm_a, 0);

    // Three mismatches inside window 0 raise the alarm.
    do_reset();
    en = 1'b1; valid = 1'b0;
    cycle();
    for (int k = 0; k < 12; k++) sample_cycle(k == 2 || k == 7 || k == 11);
    check("t3_alarm", alarm_a, 1);
    check("t3_state", state_a, 2);
    check("t3_cnt", cnt_a, 3);
    for (int k = 0; k < 4; k++) sample_cycle(1'b1);
    check("t3_cnt_frozen", cnt_a, 3);
    check("t3_state_held", state_a, 2);

    // Mismatches straddling a window boundary do not combine.
    do_reset();
    en = 1'b1; valid = 1'b0;
    cycle();
    for (int k = 0; k < 17; k++) sample_cycle(k == 14 || k == 15 || k == 16);
    check("t4_alarm", alarm_a, 0);
    check("t4_cnt", cnt_a, 3);
    sample_cycle(1'b1);
    check("t4_w1_two", alarm_a, 0);
    sample_cycle(1'b1);
    check("t4_w1_three", alarm_a, 1);

    // Clear in ALARM together with a mismatching sample.
    clear = 1'b1; valid = 1'b1; golden_out = 1'b0; dut_out = 1'b1;
    cycle();
    clear = 1'b0; valid = 1'b0;
    check("t5_alarm", alarm_a, 0);
    check("t5_cnt", cnt_a, 0);
    check("t5_tsv", ts_valid_a, 0);
    check("t5_state", state_a, 1);
    t0 = m_ts;
    en = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check("t5_idle", state_a, 0);
    en = 1'b1;
    cycle();
    sample_cycle(1'b1);
    check("t5_ts_held", first_ts_a, t0 + 1);

    // Saturation of the narrow counter, then an async reset mid-window.
    do_reset();
    en = 1'b1; valid = 1'b0;
    cycle();
    for (int w = 0; w < 5; w++)
      for (int k = 0; k < WIN_LEN; k++) sample_cycle(k == 0);
    check("t6_cnt_sat", cnt_s, 3);
    check("t6_cnt", cnt_a, 5);
    check("t6_alarm", alarm_a, 0);
    for (int k = 0; k < 5; k++) sample_cycle(k == 2);
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) begin
        do_reset();
      end else begin
        en         = ($urandom_range(7) != 0);
        valid      = ($urandom_range(3) != 0);
        clear      = ($urandom_range(59) == 0);
        golden_out = 1'($urandom_range(1));
        dut_out    = golden_out ^ 1'($urandom_range(5) == 0);
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
